// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the row-address
// helper used by the pixel-fetch stage.
package vga_pkg;

    localparam int H_ATIVO_INI = 144;
    localparam int H_ATIVO_FIM = 782;
    localparam int V_ATIVO_INI = 36;
    localparam int V_ATIVO_FIM = 514;

    localparam int SRC_W = 320;
    localparam int SRC_H = 240;
    localparam int FB_AW = 17;

    // What the output register does on a given cycle.
    typedef enum logic [1:0] {
        LD_ZERO = 2'd0,
        LD_POP  = 2'd1,
        LD_HOLD = 2'd2
    } load_t;

    // Byte address of the first pixel of source row r: base + r*320,
    // built from two shifts so no multiplier is needed.
    function automatic logic [FB_AW-1:0] row_start(input logic [FB_AW-1:0] base,
                                                   input logic [8:0]       r);
        logic [FB_AW-1:0] rw;
        rw = {{(FB_AW-9){1'b0}}, r};
        return base + (rw << 8) + (rw << 6);
    endfunction

endpackage

// File: rtl/fifo_pixel.sv
// Synchronous prefetch FIFO for 8-bit palette indices. Registered storage,
// no fall-through: a pushed byte becomes visible on the following cycle.
// Clear has priority over push and pop.
module fifo_pixel #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    // Storage write; data array is not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/leitor_pixel.sv
// Pixel-fetch stage feeding the VGA colour block. Follows the timing
// counters, prefetches one 320-byte source row per active line over an
// in-order request/grant read port, and doubles pixels in x and y.
// Optional macro LEITOR_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module leitor_pixel
    import vga_pkg::*;
#(
    parameter logic [16:0] BASE        = 17'h0,
    parameter int          DEPTH       = 16,
    parameter int          FETCH_START = 0,
    parameter logic [7:0]  UNDER_COLOR = 8'hF9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  contclk,
    input  logic [9:0]  l,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  cor_out,
    output logic        underflow
`ifdef LEITOR_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [9:0]  LD_INI = 10'(H_ATIVO_INI - 1);

    logic          line_act;
    logic          line_start;
    logic [8:0]    r;
    logic [8:0]    issued;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] out_next;
    logic [CW-1:0] fifo_count;
    logic          fetch_on;
    logic          acc;
    logic          drop;
    logic          ret_keep;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_dout;
    load_t         load;

    assign line_act   = (l >= 10'(V_ATIVO_INI)) && (l <= 10'(V_ATIVO_FIM));
    assign line_start = line_act && (contclk == 10'(FETCH_START));
    assign r          = 9'((l - 10'(V_ATIVO_INI)) >> 1);

    // Requests stop once the row is issued or buffer plus in-flight beats
    // would fill the FIFO; that sum only grows on a grant, so a pending
    // request cannot drop before it is accepted.
    assign mem_req  = fetch_on && (issued < 9'(SRC_W)) &&
                      (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign acc      = mem_req && mem_gnt;
    assign out_next = outstanding + CW'(acc) - CW'(mem_rvalid);

    // A beat returning on the line-start cycle is already counted in the
    // discard value latched that cycle, so it is dropped here.
    assign drop     = mem_rvalid && (line_start || (discard != '0));
    assign ret_keep = mem_rvalid && !drop;
    assign push     = ret_keep && !fifo_full;

    // Load decision for column x' = contclk + 1 - 144; x' even pops.
    always_comb begin
        load = LD_ZERO;
        if (line_act && (contclk >= LD_INI) && (contclk <= 10'(H_ATIVO_FIM))) begin
            load = (contclk[0] == LD_INI[0]) ? LD_POP : LD_HOLD;
        end
    end

    fifo_pixel #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (line_start),
        .push  (push),
        .din   (mem_rdata),
        .pop   (load == LD_POP),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Request side: row restart on line start, address walk on grant, and
    // in-flight / discard bookkeeping. A grant on the line-start cycle still
    // belongs to the old row, so it is folded into the discard count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_on    <= 1'b0;
            issued      <= '0;
            mem_addr    <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_next;
            if (line_start) begin
                fetch_on <= 1'b1;
                issued   <= '0;
                mem_addr <= row_start(BASE, r);
                discard  <= out_next;
            end else begin
                if (acc) begin
                    issued   <= issued + 1'b1;
                    mem_addr <= mem_addr + 1'b1;
                end
                if (mem_rvalid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    // Output register: pop head, hold on odd columns, zero outside the picture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cor_out   <= 8'h00;
            underflow <= 1'b0;
        end else begin
            case (load)
                LD_POP: begin
                    if (fifo_empty) begin
                        cor_out   <= UNDER_COLOR;
                        underflow <= 1'b1;
                    end else begin
                        cor_out <= fifo_dout;
                    end
                end
                LD_HOLD: ;
                default: cor_out <= 8'h00;
            endcase
        end
    end

`ifdef LEITOR_UNDERFLOW_CNT_EN
    // Saturating count of pops that found the FIFO empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_cnt <= 16'h0000;
        end else if ((load == LD_POP) && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_leitor_pixel.sv
// Bench for leitor_pixel: drives the timing counters line by line, models an
// in-order memory with configurable grant rate/latency, and checks captured
// cor_out against hand-computed vectors and a pixel-address model.
`timescale 1ns/1ps
module tb_leitor_pixel;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  contclk;
    logic [9:0]  l;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic [7:0]  cor_out;
    logic        underflow;
`ifdef LEITOR_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    always #5 clk = ~clk;

    leitor_pixel #(
        .BASE        (17'h0),
        .DEPTH       (DEPTH),
        .FETCH_START (0),
        .UNDER_COLOR (8'hF9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .contclk    (contclk),
        .l          (l),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .cor_out    (cor_out),
        .underflow  (underflow)
`ifdef LEITOR_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } beat_t;

    beat_t       q[$];
    int          cyc      = 0;
    int          last_due = 0;
    int          gnt_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          stall    = 1'b0;
    logic [7:0]  dmask    = 8'hFF;

    int          inv_err   = 0;
    int          addr_err  = 0;
    bit          prev_hold = 1'b0;
    logic [16:0] prev_addr = '0;
    int          prev_c    = 0;

    logic [7:0]  cap  [0:799];
    logic [7:0]  cap2 [0:5][0:799];

    typedef struct {
        int         slot;
        int         col;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Expected index for column c of line ln with perfect prefetch.
    function automatic logic [7:0] exp_pix(input int ln, input int c, input logic [7:0] mask);
        int a;
        if (ln < 36 || ln > 514 || c < 144 || c > 783) return 8'h00;
        a = ((ln - 36) / 2) * 320 + (c - 144) / 2;
        return 8'(a & 255) & mask;
    endfunction

    // One clock: sample cor_out for column c, run the memory model, drive counters.
    task automatic step(input int ln, input int c);
        int lat;
        int d;
        @(negedge clk);
        cyc++;
        cap[c] = cor_out;
        if (prev_hold && prev_c != 0 && !rst) begin
            if (!mem_req || mem_addr !== prev_addr) addr_err++;
        end
        if (rst) begin
            q.delete();
            last_due   = 0;
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
            mem_gnt    = 1'b0;
        end else begin
            if (!stall && q.size() > 0 && q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q[0].data;
                void'(q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 8'h00;
            end
            mem_gnt = ($urandom_range(99) < gnt_pct);
            if (mem_req && mem_gnt) begin
                lat = $urandom_range(lat_max, lat_min);
                d   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                q.push_back('{mem_addr[7:0] & dmask, d});
                last_due = d;
            end
        end
        contclk = 10'(c);
        l       = 10'(ln);
        #1;
        if (dut.ret_keep && dut.fifo_full) inv_err++;
        if (int'(dut.fifo_count) + int'(dut.outstanding) > DEPTH) inv_err++;
        prev_hold = mem_req && !mem_gnt;
        prev_addr = mem_addr;
        prev_c    = c;
    endtask

    task automatic run_line(input int ln);
        for (int c = 0; c < 800; c++) step(ln, c);
    endtask

    task automatic save(input int s);
        for (int c = 0; c < 800; c++) cap2[s][c] = cap[c];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, i);
        rst = 1'b0;
    endtask

    task automatic check_line(input int ln, input logic [7:0] mask);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int c = 0; c < 800; c++) begin
            if (cap[c] !== exp_pix(ln, c, mask)) begin
                bad++;
                if (first < 0) first = c;
            end
        end
        chk($sformatf("line%0d_model_mismatches(first col %0d)", ln, first), bad, 0);
    endtask

    // Random-timing check: pixels must appear in address order, each doubled,
    // with the underflow colour allowed in place of a pixel.
    task automatic check_line_tol(input int ln, input logic [7:0] mask);
        int bad;
        int idx;
        int nu;
        int base;
        logic [7:0] v;
        bad  = 0;
        idx  = 0;
        nu   = 0;
        base = ((ln - 36) / 2) * 320;
        for (int c = 0; c < 800; c++) begin
            if ((c < 144 || c > 783) && cap[c] !== 8'h00) bad++;
        end
        for (int c = 144; c < 784; c += 2) begin
            v = cap[c];
            if (cap[c+1] !== v) bad++;
            if (v === 8'hF9) nu++;
            else if (v === (8'((base + idx) & 255) & mask)) idx++;
            else bad++;
        end
        chk($sformatf("rand_line%0d_order", ln), bad, 0);
        if (nu > 0) chk($sformatf("rand_line%0d_underflow_flag", ln), int'(underflow), 1);
    endtask

    initial begin
        rst        = 1'b1;
        contclk    = '0;
        l          = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;

        vt.push_back('{0, 143, 8'h00, "l36_c143"});
        vt.push_back('{0, 144, 8'h00, "l36_c144"});
        vt.push_back('{0, 145, 8'h00, "l36_c145"});
        vt.push_back('{0, 146, 8'h01, "l36_c146"});
        vt.push_back('{0, 147, 8'h01, "l36_c147"});
        vt.push_back('{0, 400, 8'h80, "l36_c400"});
        vt.push_back('{0, 782, 8'h3F, "l36_c782"});
        vt.push_back('{0, 783, 8'h3F, "l36_c783"});
        vt.push_back('{0, 784, 8'h00, "l36_c784"});
        vt.push_back('{2, 144, 8'h40, "l38_c144"});
        vt.push_back('{2, 146, 8'h41, "l38_c146"});
        vt.push_back('{2, 782, 8'h7F, "l38_c782"});
        vt.push_back('{3, 144, 8'hC0, "l514_c144"});
        vt.push_back('{3, 782, 8'hFF, "l514_c782"});
        vt.push_back('{4, 144, 8'h00, "l515_c144"});
        vt.push_back('{5, 143, 8'h00, "nognt_c143"});
        vt.push_back('{5, 144, 8'hF9, "nognt_c144"});
        vt.push_back('{5, 145, 8'hF9, "nognt_c145"});
        vt.push_back('{5, 146, 8'hF9, "nognt_c146"});
        vt.push_back('{5, 783, 8'hF9, "nognt_c783"});
        vt.push_back('{5, 784, 8'h00, "nognt_c784"});

        // Reset state
        for (int i = 0; i < 3; i++) step(0, i);
        chk("rst_cor_out", int'(cor_out), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_underflow", int'(underflow), 0);
        rst = 1'b0;

        // Fast memory: gnt always, one-cycle latency, data = addr[7:0]
        run_line(35);
        run_line(36); save(0); check_line(36, 8'hFF);
        run_line(37); save(1); check_line(37, 8'hFF);
        run_line(38); save(2); check_line(38, 8'hFF);
        run_line(514); save(3); check_line(514, 8'hFF);
        run_line(515); save(4); check_line(515, 8'hFF);
        begin
            int diff;
            diff = 0;
            for (int c = 0; c < 800; c++) if (cap2[0][c] !== cap2[1][c]) diff++;
            chk("l36_vs_l37_diffs", diff, 0);
        end
        chk("fast_underflow", int'(underflow), 0);

        // Grant withheld for a whole line
        gnt_pct = 0;
        run_line(40); save(5);
        chk("nognt_underflow", int'(underflow), 1);
`ifdef LEITOR_UNDERFLOW_CNT_EN
        chk("nognt_underflow_cnt", int'(underflow_cnt), 320);
`endif

        foreach (vt[i]) chk(vt[i].name, int'(cap2[vt[i].slot][vt[i].col]), int'(vt[i].exp));

        // Random grant and latency, in-order returns
        do_reset();
        chk("reset_clears_underflow", int'(underflow), 0);
        gnt_pct = 50; lat_min = 1; lat_max = 6; dmask = 8'h7F;
        run_line(44); check_line_tol(44, 8'h7F);
        run_line(45); check_line_tol(45, 8'h7F);

        // Returns stalled across the next line start
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; dmask = 8'hFF;
        for (int c = 0; c < 800; c++) begin
            if (c == 300) stall = 1'b1;
            step(41, c);
        end
        for (int c = 0; c < 800; c++) begin
            if (c == 5) stall = 1'b0;
            step(42, c);
        end
        chk("stale_first_pixel", int'(cap[144]), 8'hC0);
        chk("stale_second_pixel", int'(cap[146]), 8'hC1);
        check_line(42, 8'hFF);
        chk("stall_underflow", int'(underflow), 1);

        // Asynchronous reset in the middle of a slow fetch
        gnt_pct = 30; lat_min = 1; lat_max = 6;
        for (int c = 0; c <= 400; c++) step(43, c);
        chk("pre_rst_addr_nonzero", int'(mem_addr != 17'h0), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_cor_out", int'(cor_out), 0);
        chk("async_rst_mem_req", int'(mem_req), 0);
        chk("async_rst_mem_addr", int'(mem_addr), 0);
        chk("async_rst_underflow", int'(underflow), 0);
        for (int c = 401; c < 405; c++) step(43, c);
        rst = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int c = 405; c < 800; c++) step(43, c);
        run_line(44); check_line(44, 8'hFF);

        chk("no_push_into_full_or_overcommit", inv_err, 0);
        chk("addr_stable_while_waiting_gnt", addr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
